// File: rtl/cell_render.sv
// ---------------------------------------------------------------------------
// cell_render
// Pixel shader for a cellular-automaton display. It turns the raster position
// and the state of the cell under that pixel into an RGB444 colour. The
// colour is registered, so the result appears one clock after the inputs.
//
// Ports
//   clk_in       pixel clock; all state changes happen on its rising edge
//   rst_in       synchronous, active-high reset; forces pix_out to black
//   is_alive_in  state of the cell that contains (hcount_in, vcount_in)
//   hcount_in    current pixel column (11 bits, unsigned)
//   vcount_in    current pixel row (10 bits, unsigned)
//   pix_out      registered colour {R[3:0], G[3:0], B[3:0]}
//
// Colour priority: blanking, then grid lines, then cell interior.
// ---------------------------------------------------------------------------
module cell_render #(
    parameter int          SCREEN_WIDTH  = 1024,
    parameter int          SCREEN_HEIGHT = 768,
    parameter int          CELL_SIZE     = 8,
    parameter int          GRID_EN       = 1,
    parameter logic [11:0] ALIVE_COLOR   = 12'hFFF,
    parameter logic [11:0] DEAD_COLOR    = 12'h000,
    parameter logic [11:0] GRID_COLOR    = 12'h333
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        is_alive_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    output logic [11:0] pix_out
);

    // CELL_SIZE is a power of two from 2 to 64, so this is at least 1 and the
    // low CELL_BITS bits of a counter are the position inside a cell.
    localparam int CELL_BITS = $clog2(CELL_SIZE);

    // Screen limits widened to 32 bits so a limit equal to 2^11 or 2^10 does
    // not wrap to zero when compared against the counters.
    localparam logic [31:0] H_LIMIT = 32'(SCREEN_WIDTH);
    localparam logic [31:0] V_LIMIT = 32'(SCREEN_HEIGHT);

    logic [11:0] pix_p1;

    function automatic logic [11:0] shade(
        input logic        alive,
        input logic [10:0] h,
        input logic [9:0]  v
    );
        logic blank;
        logic on_grid;
        blank   = ({21'd0, h} >= H_LIMIT) || ({22'd0, v} >= V_LIMIT);
        on_grid = (GRID_EN != 0) &&
                  ((h[CELL_BITS-1:0] == '0) || (v[CELL_BITS-1:0] == '0));
        if (blank)
            shade = 12'h000;
        else if (on_grid)
            shade = GRID_COLOR;
        else if (alive)
            shade = ALIVE_COLOR;
        else
            shade = DEAD_COLOR;
    endfunction

    // ---- stage p0 -> p1: colour register (the only state in the block) ----
    always_ff @(posedge clk_in) begin
        if (rst_in)
            pix_p1 <= 12'h000;
        else
            pix_p1 <= shade(is_alive_in, hcount_in, vcount_in);
    end

    assign pix_out = pix_p1;

endmodule

// File: tb/tb_cell_render.sv
// ---------------------------------------------------------------------------
// tb_cell_render
// Self-checking bench for cell_render. Three instances share one stimulus
// stream: the default configuration, a copy with the grid disabled, and a
// small screen with distinct colours and 4-pixel cells. Each driven pixel
// pushes the reference colour of every instance onto its own queue; after
// the clock edge the queues are popped and compared with the outputs.
// ---------------------------------------------------------------------------
module tb_cell_render;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alive = 1'b0;
    logic [10:0] hc = '0;
    logic [9:0]  vc = '0;
    logic [11:0] pix_def, pix_ng, pix_sm;

    int checks = 0;
    int failures = 0;

    logic [11:0] q_def[$];
    logic [11:0] q_ng[$];
    logic [11:0] q_sm[$];

    always #5 clk = ~clk;

    cell_render u_def (
        .clk_in(clk), .rst_in(rst), .is_alive_in(alive),
        .hcount_in(hc), .vcount_in(vc), .pix_out(pix_def)
    );

    cell_render #(.GRID_EN(0)) u_ng (
        .clk_in(clk), .rst_in(rst), .is_alive_in(alive),
        .hcount_in(hc), .vcount_in(vc), .pix_out(pix_ng)
    );

    cell_render #(
        .SCREEN_WIDTH(40), .SCREEN_HEIGHT(24), .CELL_SIZE(4), .GRID_EN(1),
        .ALIVE_COLOR(12'hA5C), .DEAD_COLOR(12'h123), .GRID_COLOR(12'h0F0)
    ) u_sm (
        .clk_in(clk), .rst_in(rst), .is_alive_in(alive),
        .hcount_in(hc), .vcount_in(vc), .pix_out(pix_sm)
    );

    // Reference colour written straight from the behavioural description.
    function automatic logic [11:0] ref_pix(
        input int w, input int ht, input int cs, input bit ge,
        input logic [11:0] ca, input logic [11:0] cd, input logic [11:0] cg,
        input bit a, input int h, input int v
    );
        if (h >= w || v >= ht) return 12'h000;
        if (ge && ((h % cs) == 0 || (v % cs) == 0)) return cg;
        return a ? ca : cd;
    endfunction

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (h=%0d v=%0d)", tag, got, exp, hc, vc);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [11:0] e;
        if (q_def.size() == 0 || q_ng.size() == 0 || q_sm.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_queue: got empty scoreboard expected entry", tag);
        end else begin
            e = q_def.pop_front(); check({tag, "_def"}, pix_def, e);
            e = q_ng.pop_front();  check({tag, "_nogrid"}, pix_ng, e);
            e = q_sm.pop_front();  check({tag, "_small"}, pix_sm, e);
        end
    endtask

    // Drive one pixel, record expectations, wait one edge and compare.
    task automatic step(input string tag, input bit r, input bit a, input int h, input int v);
        rst   = r;
        alive = a;
        hc    = h[10:0];
        vc    = v[9:0];
        if (r) begin
            q_def.push_back(12'h000);
            q_ng.push_back(12'h000);
            q_sm.push_back(12'h000);
        end else begin
            q_def.push_back(ref_pix(1024, 768, 8, 1'b1, 12'hFFF, 12'h000, 12'h333, a, h, v));
            q_ng.push_back(ref_pix(1024, 768, 8, 1'b0, 12'hFFF, 12'h000, 12'h333, a, h, v));
            q_sm.push_back(ref_pix(40, 24, 4, 1'b1, 12'hA5C, 12'h123, 12'h0F0, a, h, v));
        end
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        bit tog;
        @(negedge clk);

        // Reset then immediate release.
        step("reset", 1'b1, 1'b1, 5, 5);
        step("reset_release", 1'b0, 1'b1, 5, 5);

        // Directed pixels, including grid, blanking and edge cases.
        step("cell_alive", 1'b0, 1'b1, 9, 9);
        step("cell_dead", 1'b0, 1'b0, 9, 9);
        step("grid_col", 1'b0, 1'b1, 16, 3);
        step("grid_row", 1'b0, 1'b0, 3, 0);
        step("grid_origin", 1'b0, 1'b1, 0, 0);
        step("blank_h", 1'b0, 1'b1, 1024, 10);
        step("blank_v", 1'b0, 1'b1, 10, 768);
        step("blank_max", 1'b0, 1'b1, 2047, 1023);
        step("edge_last", 1'b0, 1'b1, 1023, 767);
        step("edge_77", 1'b0, 1'b1, 7, 7);
        step("edge_87", 1'b0, 1'b1, 8, 7);
        step("small_blank", 1'b0, 1'b1, 40, 5);
        step("small_last", 1'b0, 1'b1, 39, 23);

        // Reset in the middle of a line, then normal operation resumes.
        step("mid_reset", 1'b1, 1'b1, 9, 9);
        step("mid_release", 1'b0, 1'b0, 10, 9);
        step("mid_after", 1'b0, 1'b1, 11, 9);

        // Small frame fully covered, with blanking margin, alive toggling.
        tog = 1'b0;
        for (int v = 0; v < 28; v++) begin
            for (int h = 0; h < 48; h++) begin
                step("sweep_small", 1'b0, tog, h, v);
                tog = ~tog;
            end
        end

        // Full-width lines at the top and bottom of the default frame,
        // continuous raster with no idle cycles between pixels.
        for (int v = 0; v < 770; v++) begin
            if (v == 12) v = 760;
            for (int h = 0; h < 1024; h++) begin
                step("sweep_full", 1'b0, tog, h, v);
                tog = ~tog;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
